tap_controller: RTL

TAP_CONTROLLER -- requirements
Module: tap_controller

---
 rtl/tap_controller.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/tap_controller.sv
// tap_controller: IEEE 1149.1-style TAP controller with a 2-bit instruction
// register, a 1-bit bypass register and the control signals for an external
// boundary-scan chain.
//
// Ports
//   TCK       in   sole clock, rising edge
//   Reset     in   synchronous active-high reset
//   TMS       in   test mode select
//   TDI       in   serial data in (IR, bypass, boundary chain)
//   ChainOut  in   shift output of the last boundary cell
//   ChainIn   out  shift input of the first boundary cell (= TDI)
//   TDO       out  serial data out (combinational)
//   ShiftDR   out  boundary cell shift-path select
//   ClockDR   out  boundary cell capture/shift enable
//   UpdateDR  out  boundary cell update enable
//   Mode      out  boundary cell output mux select (1 = test data)
//   Instr     out  current instruction
//   State     out  current TAP state code
//
// state  | meaning
// -------+-----------------------------------------------
// TLR  F | test-logic-reset, instruction forced to BYPASS
// RTI  C | run-test/idle
// SDR  7 | select DR scan
// CDR  6 | capture DR (bypass <= 0, boundary capture)
// SHDR 2 | shift DR
// E1DR 1 | exit1 DR
// PDR  3 | pause DR
// E2DR 0 | exit2 DR
// UDR  5 | update DR (UpdateDR pulse)
// SIR  4 | select IR scan
// CIR  E | capture IR (IR shift <= 01)
// SHIR A | shift IR
// E1IR 9 | exit1 IR
// PIR  B | pause IR
// E2IR 8 | exit2 IR
// UIR  D | update IR (Instr loaded on the leaving edge)

module tap_controller #(
   parameter int IR_WIDTH = 2
) (
   input  logic                TCK,
   input  logic                Reset,
   input  logic                TMS,
   input  logic                TDI,
   input  logic                ChainOut,
   output logic                ChainIn,
   output logic                TDO,
   output logic                ShiftDR,
   output logic                ClockDR,
   output logic                UpdateDR,
   output logic                Mode,
   output logic [IR_WIDTH-1:0] Instr,
   output logic [3:0]          State
);

   typedef enum logic [3:0] {
      TLR  = 4'hF,
      RTI  = 4'hC,
      SDR  = 4'h7,
      CDR  = 4'h6,
      SHDR = 4'h2,
      E1DR = 4'h1,
      PDR  = 4'h3,
      E2DR = 4'h0,
      UDR  = 4'h5,
      SIR  = 4'h4,
      CIR  = 4'hE,
      SHIR = 4'hA,
      E1IR = 4'h9,
      PIR  = 4'hB,
      E2IR = 4'h8,
      UIR  = 4'hD
   } tap_state_e;

   localparam logic [IR_WIDTH-1:0] EXTEST     = IR_WIDTH'(0);
   localparam logic [IR_WIDTH-1:0] SAMPLE     = IR_WIDTH'(1);
   localparam logic [IR_WIDTH-1:0] INTEST     = IR_WIDTH'(2);
   localparam logic [IR_WIDTH-1:0] BYPASS     = IR_WIDTH'(3);
   localparam logic [IR_WIDTH-1:0] IR_CAPTURE = SAMPLE;

   tap_state_e          state_q, state_d;
   logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
   logic [IR_WIDTH-1:0] instr_q, instr_d;
   logic                bypass_q, bypass_d;
   logic                shift_dr_q, shift_dr_d;
   logic                clock_dr_q, clock_dr_d;
   logic                update_dr_q, update_dr_d;
   logic                mode_q, mode_d;
   logic                dr_active;

   always_comb begin
      state_d = state_q;
      case (state_q)
         TLR:     state_d = TMS ? TLR  : RTI;
         RTI:     state_d = TMS ? SDR  : RTI;
         SDR:     state_d = TMS ? SIR  : CDR;
         CDR:     state_d = TMS ? E1DR : SHDR;
         SHDR:    state_d = TMS ? E1DR : SHDR;
         E1DR:    state_d = TMS ? UDR  : PDR;
         PDR:     state_d = TMS ? E2DR : PDR;
         E2DR:    state_d = TMS ? UDR  : SHDR;
         UDR:     state_d = TMS ? SDR  : RTI;
         SIR:     state_d = TMS ? TLR  : CIR;
         CIR:     state_d = TMS ? E1IR : SHIR;
         SHIR:    state_d = TMS ? E1IR : SHIR;
         E1IR:    state_d = TMS ? UIR  : PIR;
         PIR:     state_d = TMS ? E2IR : PIR;
         E2IR:    state_d = TMS ? UIR  : SHIR;
         UIR:     state_d = TMS ? SDR  : RTI;
         default: state_d = TLR;
      endcase
   end

   always_comb begin
      ir_shift_d = ir_shift_q;
      case (state_q)
         CIR:     ir_shift_d = IR_CAPTURE;
         SHIR:    ir_shift_d = {TDI, ir_shift_q[IR_WIDTH-1:1]};
         default: ir_shift_d = ir_shift_q;
      endcase
   end

   // BYPASS is forced both on the edge entering TLR and while sitting in it,
   // so Mode drops together with the arrival in TLR.
   always_comb begin
      instr_d = instr_q;
      if (state_q == UIR) begin
         instr_d = ir_shift_q;
      end
      if ((state_q == TLR) || (state_d == TLR)) begin
         instr_d = BYPASS;
      end
   end

   always_comb begin
      bypass_d = bypass_q;
      if (state_q == CDR) begin
         bypass_d = 1'b0;
      end else if ((state_q == SHDR) && (instr_q == BYPASS)) begin
         bypass_d = TDI;
      end
   end

   // Boundary-chain controls are registered from the next state/instruction,
   // so they are pure functions of the current State/Instr with no TMS path.
   always_comb begin
      dr_active   = (instr_d != BYPASS);
      shift_dr_d  = (state_d == SHDR) && dr_active;
      clock_dr_d  = ((state_d == CDR) || (state_d == SHDR)) && dr_active;
      update_dr_d = (state_d == UDR) && dr_active;
      mode_d      = (instr_d == EXTEST) || (instr_d == INTEST);
   end

   always_ff @(posedge TCK) begin
      if (Reset) begin
         state_q     <= TLR;
         ir_shift_q  <= IR_CAPTURE;
         instr_q     <= BYPASS;
         bypass_q    <= 1'b0;
         shift_dr_q  <= 1'b0;
         clock_dr_q  <= 1'b0;
         update_dr_q <= 1'b0;
         mode_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ir_shift_q  <= ir_shift_d;
         instr_q     <= instr_d;
         bypass_q    <= bypass_d;
         shift_dr_q  <= shift_dr_d;
         clock_dr_q  <= clock_dr_d;
         update_dr_q <= update_dr_d;
         mode_q      <= mode_d;
      end
   end

   always_comb begin
      TDO = 1'b0;
      case (state_q)
         SHIR:    TDO = ir_shift_q[0];
         SHDR:    TDO = (instr_q == BYPASS) ? bypass_q : ChainOut;
         default: TDO = 1'b0;
      endcase
   end

   assign ChainIn  = TDI;
   assign ShiftDR  = shift_dr_q;
   assign ClockDR  = clock_dr_q;
   assign UpdateDR = update_dr_q;
   assign Mode     = mode_q;
   assign Instr    = instr_q;
   assign State    = state_q;

endmodule
